// File: rtl/ex_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ex_mdu_pkg
// Purpose : Shared definitions for the EX-stage multiply/divide unit:
//           op_i encodings, FSM state encoding, default operand width and
//           the divide-by-zero quotient fill value.
// Revision: 1.0 - initial release
// ============================================================================
package ex_mdu_pkg;

    localparam int MDU_WIDTH_DEFAULT = 32;

    // op_i encodings
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVZERO = 2'd1,
        ST_ON      = 2'd2,
        ST_END     = 2'd3
    } state_t;

    // Every quotient bit is this value on a divide by zero (all-ones quotient)
    localparam logic DIVZERO_QUOT_FILL = 1'b1;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage : ex_mdu_pkg
`default_nettype wire

// File: rtl/ex_mdu_signfix.sv
`default_nettype none
// ============================================================================
// Module  : mdu_signfix
// Purpose : Sign conditioning for signed MULT/DIV. Converts incoming operands
//           to magnitudes (reporting their signs) and applies the sign fixup
//           to the unsigned raw result:
//             multiply : product negated when operand signs differ
//             divide   : quotient negated when signs differ, remainder takes
//                        the sign of the dividend
// Ports   : op_signed      - current op_i selects a signed operation
//           a, b           - raw operands from the pipeline
//           a_abs, b_abs   - operand magnitudes
//           a_neg, b_neg   - operand is negative (only when op_signed)
//           is_div         - latched operation is a divide
//           sign_a, sign_b - latched operand signs
//           res_raw        - unsigned result {hi, lo}
//           res_fixed      - sign-corrected result {hi, lo}
// Revision: 1.0 - initial release
// ============================================================================
module mdu_signfix
    import ex_mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH_DEFAULT
) (
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     a_abs,
    output logic [WIDTH-1:0]     b_abs,
    output logic                 a_neg,
    output logic                 b_neg,
    input  logic                 is_div,
    input  logic                 sign_a,
    input  logic                 sign_b,
    input  logic [2*WIDTH-1:0]   res_raw,
    output logic [2*WIDTH-1:0]   res_fixed
);

    assign a_neg = op_signed & a[WIDTH-1];
    assign b_neg = op_signed & b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    always_comb begin
        res_fixed = res_raw;
        if (is_div) begin
            if (sign_a ^ sign_b) begin
                res_fixed[WIDTH-1:0] = -res_raw[WIDTH-1:0];
            end
            if (sign_a) begin
                res_fixed[2*WIDTH-1:WIDTH] = -res_raw[2*WIDTH-1:WIDTH];
            end
        end else if (sign_a ^ sign_b) begin
            res_fixed = -res_raw;
        end
    end

endmodule : mdu_signfix
`default_nettype wire

// File: rtl/ex_mdu.sv
`default_nettype none
// ============================================================================
// Module  : ex_mdu
// Purpose : Iterative multiply/divide unit for the EX stage. One bit per
//           cycle: shift-add multiply, restoring shift-subtract divide.
//           WIDTH iterations per operation, one-cycle result for divide by
//           zero. Result is {hi, lo}: product, or {remainder, quotient}.
// Config  : MDU_SIGNED_EN - when defined, MULT/DIV are signed (operands
//           converted to magnitudes, sign fixup on completion). When
//           undefined, every op is unsigned and no sign logic is built.
// Ports   : clk        - rising-edge clock
//           Rst_n      - synchronous active-low reset
//           start_i    - request new operation (sampled in IDLE only)
//           op_i       - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//           opdata1_i  - multiplicand / dividend
//           opdata2_i  - multiplier / divisor
//           annul_i    - flush: abandon any in-flight operation
//           result_o   - registered result, held until the next completion
//           ready_o    - one-cycle pulse, result_o valid
//           stallreq_o - combinational request to hold EX
// Revision: 1.0 - initial release
// ============================================================================
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 Rst_n,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    // acc holds {hi, lo}: multiply {partial product, remaining multiplier},
    // divide {partial remainder, dividend bits shifting into quotient}
    logic [2*WIDTH-1:0]   acc;
    // multiplicand for multiply, divisor for divide
    logic [WIDTH-1:0]     opnd;
    logic                 is_div;

    logic                 new_is_div;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   res_raw;
    logic [2*WIDTH-1:0]   res_fixed;

    assign new_is_div = op_is_div(op_i);

    // ---------------------------------------------------------------- sign
`ifdef MDU_SIGNED_EN
    logic sign_a;
    logic sign_b;
    logic a_neg;
    logic b_neg;

    mdu_signfix #(
        .WIDTH     (WIDTH)
    ) u_signfix (
        .op_signed (op_is_signed(op_i)),
        .a         (opdata1_i),
        .b         (opdata2_i),
        .a_abs     (a_abs),
        .b_abs     (b_abs),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .is_div    (is_div),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .res_raw   (res_raw),
        .res_fixed (res_fixed)
    );
`else
    assign a_abs     = opdata1_i;
    assign b_abs     = opdata2_i;
    assign res_fixed = res_raw;
`endif

    // ------------------------------------------------------------ datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, opnd};
    // When div_ge the true difference is below the divisor, so W bits suffice
    assign div_diff = div_sh[WIDTH-1:0] - opnd;

    always_comb begin
        if (is_div) begin
            acc_next = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // In DIVZERO the magnitude of the dividend goes through the remainder
    // fixup so the original dividend comes back out in the hi half.
    assign res_raw = (state == ST_DIVZERO) ? {acc[WIDTH-1:0], {WIDTH{1'b0}}} : acc_next;

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
`ifdef MDU_SIGNED_EN
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_o <= 1'b0;
                    if (start_i && !annul_i) begin
                        is_div <= new_is_div;
                        cnt    <= '0;
`ifdef MDU_SIGNED_EN
                        sign_a <= a_neg;
                        sign_b <= b_neg;
`endif
                        if (new_is_div) begin
                            opnd <= b_abs;
                            acc  <= {{WIDTH{1'b0}}, a_abs};
                        end else begin
                            opnd <= a_abs;
                            acc  <= {{WIDTH{1'b0}}, b_abs};
                        end
                        state <= (new_is_div && (opdata2_i == '0)) ? ST_DIVZERO : ST_ON;
                    end
                end
                ST_DIVZERO: begin
                    if (annul_i) begin
                        state <= ST_IDLE;
                    end else begin
                        result_o <= {res_fixed[2*WIDTH-1:WIDTH], {WIDTH{DIVZERO_QUOT_FILL}}};
                        ready_o  <= 1'b1;
                        state    <= ST_END;
                    end
                end
                ST_ON: begin
                    if (annul_i) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_ITER) begin
                            result_o <= res_fixed;
                            ready_o  <= 1'b1;
                            state    <= ST_END;
                        end
                    end
                end
                default: begin
                    ready_o <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        if (Rst_n) begin
            case (state)
                ST_IDLE:    stallreq_o = start_i & ~annul_i;
                ST_DIVZERO: stallreq_o = 1'b1;
                ST_ON:      stallreq_o = 1'b1;
                default:    stallreq_o = 1'b0;
            endcase
        end
    end

endmodule : ex_mdu
`default_nettype wire

// File: tb/tb_ex_mdu.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_mdu
// Purpose : Self-checking bench for ex_mdu (WIDTH=32). Results are compared
//           against an arithmetic reference model; follows MDU_SIGNED_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        Rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_hold;

    always #5 clk = ~clk;

    ex_mdu #(.WIDTH(32)) dut (
        .clk        (clk),
        .Rst_n      (Rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    // ------------------------------------------------------------ reference
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        bit          sgn;
        longint      sa, sb, sp, sq, sr;
        logic [63:0] ua, ub, up;
        logic [31:0] q32, r32;
`ifdef MDU_SIGNED_EN
        sgn = (op == 2'b00) || (op == 2'b10);
`else
        sgn = 1'b0;
`endif
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op[1] == 1'b0) begin
            if (sgn) begin
                sp = sa * sb;
                return sp;
            end
            up = ua * ub;
            return up;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sq  = sa / sb;
            sr  = sa % sb;
            q32 = sq[31:0];
            r32 = sr[31:0];
        end else begin
            q32 = a / b;
            r32 = a % b;
        end
        return {r32, q32};
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
        return (op[1] && b == 32'd0) ? 1 : 32;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------- driver
    // Starts at a negedge in IDLE, ends at the negedge after the ready pulse.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit poke,
                          output logic stall0, output int lat, output int stall_n,
                          output logic stall_end, output logic [63:0] res,
                          output logic ready_after, output logic [63:0] res_after);
        start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
        #1 stall0 = stallreq_o;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; op_i = 2'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
        lat = 0; stall_n = 0;
        while (ready_o !== 1'b1 && lat < 200) begin
            if (stallreq_o === 1'b1) stall_n++;
            if (poke && lat == 5) begin
                start_i = 1'b1; op_i = 2'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        start_i   = 1'b0;
        stall_end = stallreq_o;
        res       = result_o;
        @(negedge clk);
        ready_after = ready_o;
        res_after   = result_o;
    endtask

    // -------------------------------------------------------------- tests
    task automatic test_reset();
        Rst_n = 1'b0; start_i = 1'b1; annul_i = 1'b0; op_i = 2'b01;
        opdata1_i = $urandom; opdata2_i = $urandom;
        repeat (3) @(negedge clk);
        n_cmp++; if (result_o !== 64'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result_o); end
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        n_cmp++; if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stallreq_o); end
        start_i = 1'b0;
        Rst_n = 1'b1;
        @(negedge clk);
        exp_hold = 64'd0;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
        logic [31:0] as  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0000_0064};
        logic [31:0] bs  [4] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0002, 32'h0000_0000};
`ifdef MDU_SIGNED_EN
        logic [63:0] lit [4] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1,
                                 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0064_FFFF_FFFF};
`endif
        logic s0, se, ra; int lat, sn; logic [63:0] r, rh, e;
        for (int i = 0; i < 4; i++) begin
            e = ref_result(ops[i], as[i], bs[i]);
            run_op(ops[i], as[i], bs[i], 1'b0, s0, lat, sn, se, r, ra, rh);
            n_cmp++; if (s0 !== 1'b1) begin n_bad++; $display("FAIL dir%0d_stall_accept: got %b want 1", i, s0); end
            n_cmp++; if (r !== e) begin n_bad++; $display("FAIL dir%0d_result: got %h want %h", i, r, e); end
`ifdef MDU_SIGNED_EN
            n_cmp++; if (r !== lit[i]) begin n_bad++; $display("FAIL dir%0d_literal: got %h want %h", i, r, lit[i]); end
`endif
            n_cmp++; if (lat != ref_lat(ops[i], bs[i])) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, ref_lat(ops[i], bs[i])); end
            n_cmp++; if (sn != ref_lat(ops[i], bs[i])) begin n_bad++; $display("FAIL dir%0d_stall_cycles: got %0d want %0d", i, sn, ref_lat(ops[i], bs[i])); end
            n_cmp++; if (se !== 1'b0) begin n_bad++; $display("FAIL dir%0d_stall_end: got %b want 0", i, se); end
            n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL dir%0d_ready_pulse: got %b want 0", i, ra); end
            n_cmp++; if (rh !== e) begin n_bad++; $display("FAIL dir%0d_result_hold: got %h want %h", i, rh, e); end
            exp_hold = e;
        end
    endtask

    task automatic test_random();
        logic s0, se, ra; int lat, sn; logic [63:0] r, rh, e;
        logic [1:0] op; logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom); a = pick_operand(); b = pick_operand();
            e = ref_result(op, a, b);
            run_op(op, a, b, 1'b0, s0, lat, sn, se, r, ra, rh);
            n_cmp++; if (r !== e) begin n_bad++; $display("FAIL rnd_result op=%b a=%h b=%h: got %h want %h", op, a, b, r, e); end
            n_cmp++; if (lat != ref_lat(op, b)) begin n_bad++; $display("FAIL rnd_latency op=%b: got %0d want %0d", op, lat, ref_lat(op, b)); end
            exp_hold = e;
        end
    endtask

    task automatic test_annul();
        logic s0, se, ra; int lat, sn; logic [63:0] r, rh, e; int seen;
        // abort DIVU in ON: annul high in the cycle before E0+10
        start_i = 1'b1; op_i = 2'b11; opdata1_i = $urandom; opdata2_i = $urandom | 32'd1;
        @(posedge clk);
        @(negedge clk); start_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 9; k++) begin @(negedge clk); if (ready_o === 1'b1) seen++; end
        annul_i = 1'b1;
        @(negedge clk); annul_i = 1'b0;
        if (ready_o === 1'b1) seen++;
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL annul_on_ready: got %0d pulses want 0", seen); end
        n_cmp++; if (result_o !== exp_hold) begin n_bad++; $display("FAIL annul_on_hold: got %h want %h", result_o, exp_hold); end
        n_cmp++; if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL annul_on_stall: got %b want 0", stallreq_o); end
        // MULTU right after the flush completes normally
        e = ref_result(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, s0, lat, sn, se, r, ra, rh);
        n_cmp++; if (r !== e) begin n_bad++; $display("FAIL annul_next_result: got %h want %h", r, e); end
        n_cmp++; if (lat != 32) begin n_bad++; $display("FAIL annul_next_latency: got %0d want 32", lat); end
        exp_hold = e;
        // abort a divide-by-zero while in DIVZERO
        start_i = 1'b1; op_i = 2'b11; opdata1_i = $urandom; opdata2_i = 32'd0;
        @(posedge clk);
        @(negedge clk); start_i = 1'b0; annul_i = 1'b1;
        @(negedge clk); annul_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin if (ready_o === 1'b1) seen++; @(negedge clk); end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL annul_dz_ready: got %0d pulses want 0", seen); end
        n_cmp++; if (result_o !== exp_hold) begin n_bad++; $display("FAIL annul_dz_hold: got %h want %h", result_o, exp_hold); end
    endtask

    task automatic test_start_annul_idle();
        int seen, st;
        start_i = 1'b1; annul_i = 1'b1; op_i = 2'b01; opdata1_i = $urandom; opdata2_i = $urandom;
        #1;
        n_cmp++; if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL idle_annul_stall: got %b want 0", stallreq_o); end
        @(negedge clk); start_i = 1'b0; annul_i = 1'b0;
        seen = 0; st = 0;
        for (int k = 0; k < 40; k++) begin
            if (ready_o === 1'b1) seen++;
            if (stallreq_o === 1'b1) st++;
            @(negedge clk);
        end
        n_cmp++; if (seen != 0 || st != 0) begin n_bad++; $display("FAIL idle_annul_accept: got ready=%0d stall=%0d want 0/0", seen, st); end
    endtask

    task automatic test_ignore_and_reset();
        logic s0, se, ra; int lat, sn, seen; logic [63:0] r, rh, e;
        e = ref_result(2'b10, 32'h8000_0000, 32'h0000_0007);
        run_op(2'b10, 32'h8000_0000, 32'h0000_0007, 1'b1, s0, lat, sn, se, r, ra, rh);
        n_cmp++; if (r !== e) begin n_bad++; $display("FAIL ignore_result: got %h want %h", r, e); end
        n_cmp++; if (lat != 32 || ra !== 1'b0) begin n_bad++; $display("FAIL ignore_timing: got lat=%0d ready_after=%b want 32/0", lat, ra); end
        exp_hold = e;
        // reset in the middle of ON
        start_i = 1'b1; op_i = 2'b01; opdata1_i = $urandom; opdata2_i = $urandom;
        @(posedge clk);
        @(negedge clk); start_i = 1'b0;
        repeat (6) @(negedge clk);
        Rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (result_o !== 64'd0 || ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
            n_bad++; $display("FAIL midreset_outputs: got res=%h rdy=%b stall=%b want 0/0/0", result_o, ready_o, stallreq_o);
        end
        Rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o === 1'b1 || stallreq_o === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midreset_idle: got %0d active cycles want 0", seen); end
        exp_hold = 64'd0;
    endtask

    task automatic test_back_to_back();
        logic s0, se, ra; int lat, sn; logic [63:0] r, rh, e;
        for (int i = 0; i < 3; i++) begin
            e = ref_result(2'(i), 32'hDEAD_0000 + 32'(i), 32'h0000_0013 + 32'(i));
            run_op(2'(i), 32'hDEAD_0000 + 32'(i), 32'h0000_0013 + 32'(i), 1'b0, s0, lat, sn, se, r, ra, rh);
            n_cmp++; if (r !== e || lat != 32) begin n_bad++; $display("FAIL b2b%0d: got %h lat=%0d want %h lat=32", i, r, lat, e); end
        end
    endtask

    initial begin
        annul_i = 1'b0; start_i = 1'b0; op_i = 2'b00; opdata1_i = '0; opdata2_i = '0; Rst_n = 1'b0;
        exp_hold = 64'd0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_start_annul_idle();
        test_ignore_and_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ex_mdu
`default_nettype wire

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have port clk  input  1: rising-edge clock.
REQ-003 SHALL have port Rst_n  input  1: reset, synchronous, active-low.
REQ-004 SHALL have port start_i  input  1: request a new operation.
REQ-005 SHALL have port op_i  input  2: operation select, encoded as 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port opdata1_i  input  WIDTH: multiplicand or dividend.
REQ-007 SHALL have port opdata2_i  input  WIDTH: multiplier or divisor.
REQ-008 SHALL have port annul_i  input  1: abort any in-flight operation (pipeline flush).
REQ-009 SHALL have port result_o  output  2*WIDTH: result as {hi, lo}; for MULT/MULTU this is the product, for DIV/DIVU it is {remainder, quotient}.
REQ-010 SHALL have port ready_o  output  1: result_o valid, asserted as a one-cycle pulse.
REQ-011 SHALL have port stallreq_o  output  1: request that the pipeline hold EX.

Function
REQ-012 SHALL implement the states IDLE, DIVZERO, ON and END.
REQ-013 IDLE SHALL accept an operation when start_i=1 and annul_i=0 at a rising edge E0, latching op_i and both operands.
REQ-014 On acceptance at E0, IDLE SHALL go to DIVZERO for a DIV/DIVU with opdata2_i=0, and to ON otherwise.
REQ-015 ON SHALL perform exactly WIDTH iterations, one per cycle: shift-add for multiply, restoring shift-subtract for divide; the iteration counter is log2(WIDTH)+1 bits.
REQ-016 ON SHALL go to END at edge E0+WIDTH.
REQ-017 DIVZERO SHALL go to END at edge E0+1.
REQ-018 For divide by zero, result_o SHALL be {dividend, all-ones quotient}.
REQ-019 END SHALL hold ready_o=1 for exactly one cycle and then return to IDLE.
REQ-020 result_o SHALL be registered on entry to END and held unchanged until the next entry to END.
REQ-021 Signed ops SHALL operate on absolute values, with sign fixup applied on entry to END.
REQ-022 The signed fixups SHALL be: product negated if operand signs differ; quotient negated if signs differ; remainder takes the sign of the dividend.
REQ-023 Divide SHALL truncate toward zero.
REQ-024 stallreq_o SHALL be combinational: 1 in IDLE when start_i=1 and annul_i=0, 1 in DIVZERO and ON, and 0 in END and otherwise.
REQ-025 start_i SHALL be ignored in every state other than IDLE.
REQ-026 annul_i=1 in DIVZERO, ON or END SHALL return the FSM to IDLE at the next edge with no ready_o pulse and result_o unchanged.
REQ-027 If start_i and annul_i are both 1 in IDLE, annul_i SHALL win and no operation is accepted.
REQ-028 An operation SHALL be accepted in the IDLE cycle immediately after END (back-to-back operation).

Reset
REQ-029 Rst_n=0 at a clock edge SHALL force IDLE, result_o=0, ready_o=0, counter=0 and the latched operands to 0, overriding all other inputs including mid-operation.
REQ-030 stallreq_o SHALL be 0 while Rst_n=0.

Configuration
REQ-031 Macro MDU_SIGNED_EN defined SHALL give MULT/DIV signed semantics per REQ-021 to REQ-022.
REQ-032 Macro MDU_SIGNED_EN undefined SHALL make op_i[0] ignored, treat all ops as unsigned, and leave no absolute-value or negation logic in the design.

Structure
REQ-033 The shared define file SHALL hold the op_i encodings, the state encodings, the WIDTH default and the divide-by-zero quotient constant.
REQ-034 Sign conditioning (absolute value in, conditional negate out) SHALL be a single sub-module mdu_signfix, instantiated only under MDU_SIGNED_EN.
REQ-035 The top level SHALL contain the FSM, the counter and the shift/add-subtract datapath.

Verification (WIDTH=32, MDU_SIGNED_EN defined)
REQ-036 MULTU FFFFFFFF x FFFFFFFF SHALL give result_o=FFFFFFFE_00000001 with ready_o in the cycle after edge E0+32, and stallreq_o high for the 32 cycles before it.
REQ-037 MULT FFFFFFFD(-3) x 00000005 SHALL give result_o=FFFFFFFF_FFFFFFF1.
REQ-038 DIV FFFFFFF9(-7) / 00000002 SHALL give result_o={FFFFFFFF, FFFFFFFD} (remainder -1, quotient -3).
REQ-039 DIVU 00000064 / 00000000 SHALL give ready_o in the cycle after E0+1 with result_o={00000064, FFFFFFFF}.
REQ-040 DIVU with annul_i pulsed at E0+10 SHALL produce no ready_o, result_o holding its prior value, and a new MULTU started the next cycle completing normally.
REQ-041 start_i re-asserted with different operands during ON SHALL be ignored, the original result returned, and reset asserted mid-ON SHALL clear all outputs at the next edge.
